// File: rtl/key_frame_tx.sv
// Serial key-frame transmitter: 14 cells (inverted pre-level, then bit level), LSB first, then a low gap.
// Optional build macro KEY_FRAME_TX_REPEAT_EN adds REPEAT_REQ to re-send the latched frame back to back.
module key_frame_tx #(
    parameter int CELL_PRE  = 'h100,
    parameter int CELL_HOLD = 'h600,
    parameter int FRAME_GAP = 'h10400
) (
    input  logic        LPC_CLK33M_GMUX,
    input  logic        GMUX_RESET,
    input  logic [13:0] FRAME_DATA,
    input  logic        FRAME_VALID,
`ifdef KEY_FRAME_TX_REPEAT_EN
    input  logic        REPEAT_REQ,
`endif
    output logic        FRAME_READY,
    output logic        KEY_TX,
    output logic        TX_BUSY,
    output logic        FRAME_DONE,
    output logic        FRAME_ERR
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        HOLD = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam logic [10:0] PRE_LAST  = 11'(CELL_PRE - 1);
    localparam logic [10:0] HOLD_LAST = 11'(CELL_HOLD - 1);
    localparam logic [16:0] GAP_LAST  = 17'(FRAME_GAP - 1);
    localparam logic [3:0]  LAST_BIT  = 4'd13;

    state_t      state_q, state_d;
    logic [13:0] shift_q, shift_d;
    logic [3:0]  index_q, index_d;
    logic [10:0] cell_cnt_q, cell_cnt_d;
    logic [16:0] gap_cnt_q, gap_cnt_d;
    logic        key_q, key_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        repeat_go;

`ifdef KEY_FRAME_TX_REPEAT_EN
    // A pending new frame wins: fall back to IDLE so it transfers next cycle.
    assign repeat_go = REPEAT_REQ & ~FRAME_VALID;
`else
    assign repeat_go = 1'b0;
`endif

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d    = state_q;
        shift_d    = shift_q;
        index_d    = index_q;
        cell_cnt_d = cell_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (FRAME_VALID) begin
                    if (FRAME_DATA[13]) begin
                        err_d = 1'b1;
                    end else begin
                        shift_d    = FRAME_DATA;
                        index_d    = 4'd0;
                        cell_cnt_d = 11'd0;
                        state_d    = PRE;
                    end
                end
            end
            PRE: begin
                if (cell_cnt_q == PRE_LAST) begin
                    cell_cnt_d = 11'd0;
                    state_d    = HOLD;
                end else begin
                    cell_cnt_d = cell_cnt_q + 11'd1;
                end
            end
            HOLD: begin
                if (cell_cnt_q == HOLD_LAST) begin
                    cell_cnt_d = 11'd0;
                    if (index_q == LAST_BIT) begin
                        gap_cnt_d = 17'd0;
                        state_d   = GAP;
                    end else begin
                        index_d = index_q + 4'd1;
                        state_d = PRE;
                    end
                end else begin
                    cell_cnt_d = cell_cnt_q + 11'd1;
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = 17'd0;
                    done_d    = 1'b1;
                    if (repeat_go) begin
                        index_d    = 4'd0;
                        cell_cnt_d = 11'd0;
                        state_d    = PRE;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 17'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level is decoded from the next state so KEY_TX is a flop aligned with state_q.
        unique case (state_d)
            IDLE:    key_d = 1'b1;
            PRE:     key_d = ~shift_d[index_d];
            HOLD:    key_d = shift_d[index_d];
            GAP:     key_d = 1'b0;
            default: key_d = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge LPC_CLK33M_GMUX or posedge GMUX_RESET) begin
        if (GMUX_RESET) begin
            state_q    <= IDLE;
            shift_q    <= 14'd0;
            index_q    <= 4'd0;
            cell_cnt_q <= 11'd0;
            gap_cnt_q  <= 17'd0;
            key_q      <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            index_q    <= index_d;
            cell_cnt_q <= cell_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            key_q      <= key_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign KEY_TX      = key_q;
    assign FRAME_READY = (state_q == IDLE);
    assign TX_BUSY     = (state_q != IDLE);
    assign FRAME_DONE  = done_q;
    assign FRAME_ERR   = err_q;

endmodule

// File: tb/tb_key_frame_tx.sv
// Scoreboard bench for key_frame_tx: per-cycle expected line/flag model plus a model receiver decoding frames.
// Timing parameters are scaled down; receiver sample delay and frame time are scaled to match.
module tb_key_frame_tx;

    localparam int PRE     = 4;
    localparam int HOLD    = 12;
    localparam int GAP     = 40;
    localparam int SAMPLE  = 8;
    localparam int FRAME_T = 32;
    localparam int T       = 14 * (PRE + HOLD) + GAP;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        valid = 1'b0;
    logic [13:0] data  = 14'd0;
    logic        rep   = 1'b0;
    logic        frame_ready, key_tx, tx_busy, frame_done, frame_err;

    key_frame_tx #(
        .CELL_PRE (PRE),
        .CELL_HOLD(HOLD),
        .FRAME_GAP(GAP)
    ) dut (
        .LPC_CLK33M_GMUX(clk),
        .GMUX_RESET     (rst),
        .FRAME_DATA     (data),
        .FRAME_VALID    (valid),
`ifdef KEY_FRAME_TX_REPEAT_EN
        .REPEAT_REQ     (rep),
`endif
        .FRAME_READY    (frame_ready),
        .KEY_TX         (key_tx),
        .TX_BUSY        (tx_busy),
        .FRAME_DONE     (frame_done),
        .FRAME_ERR      (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic key;
        logic busy;
        logic done;
        logic err;
        logic last;
    } exp_t;

    exp_t        exp_q[$];
    logic [13:0] exp_data_q[$];
    logic [13:0] dec_q[$];
    logic [13:0] latched_m = 14'd0;
    int          checks    = 0;
    int          errors    = 0;
    int          done_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t mk(logic k, logic b, logic d, logic e, logic l);
        exp_t x;
        x.key = k; x.busy = b; x.done = d; x.err = e; x.last = l;
        return x;
    endfunction

    // Expected per-cycle behaviour of one whole frame, then the IDLE cycle carrying FRAME_DONE.
    function automatic void push_frame(logic [13:0] d, logic first_done);
        for (int i = 0; i < 14; i++) begin
            for (int k = 0; k < PRE; k++)
                exp_q.push_back(mk(~d[i], 1'b1, (i == 0 && k == 0) ? first_done : 1'b0, 1'b0, 1'b0));
            for (int k = 0; k < HOLD; k++)
                exp_q.push_back(mk(d[i], 1'b1, 1'b0, 1'b0, 1'b0));
        end
        for (int k = 0; k < GAP; k++)
            exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, k == GAP - 1));
        exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
    endfunction

    // Monitor: compare this cycle, then predict the effect of the upcoming edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            check("key_tx", key_tx, e.key);
            check("tx_busy", tx_busy, e.busy);
            check("frame_ready", frame_ready, !e.busy);
            check("frame_done", frame_done, e.done);
            check("frame_err", frame_err, e.err);
            if (frame_done) begin
                done_seen++;
                check("done_has_expected_frame", exp_data_q.size() != 0, 1);
                if (exp_data_q.size() != 0) begin
                    logic [13:0] want;
                    want = exp_data_q.pop_front();
                    check("receiver_has_word", dec_q.size() != 0, 1);
                    if (dec_q.size() != 0) check("receiver_word", dec_q.pop_front(), want);
                end
            end
`ifdef KEY_FRAME_TX_REPEAT_EN
            if (e.last && rep && !valid) begin
                exp_q.delete();
                push_frame(latched_m, 1'b1);
                exp_data_q.push_back(latched_m);
            end
`endif
            if (!e.busy && valid) begin
                if (data[13]) begin
                    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
                end else begin
                    latched_m = data;
                    exp_data_q.push_back(data);
                    push_frame(data, 1'b0);
                end
            end
        end
    end

    // Model receiver: sample SAMPLE cycles after the last edge; FRAME_T cycles low ends the frame.
    logic        rx_prev   = 1'b1;
    logic        rx_active = 1'b0;
    int          rx_cnt    = 0;
    int          rx_nb     = 0;
    logic [13:0] rx_sh     = 14'd0;

    always @(negedge clk) begin
        if (rst) begin
            rx_prev = 1'b1; rx_active = 1'b0; rx_cnt = 0; rx_nb = 0;
        end else begin
            if (key_tx !== rx_prev) begin
                if (!key_tx && !rx_active) begin
                    rx_active = 1'b1;
                    rx_nb     = 0;
                end
                rx_prev = key_tx;
                rx_cnt  = 0;
            end else if (rx_cnt < 100000) begin
                rx_cnt++;
            end
            if (rx_active && rx_cnt == SAMPLE && rx_nb < 14) begin
                rx_sh[rx_nb] = key_tx;
                rx_nb++;
            end
            if (rx_active && !key_tx && rx_cnt == FRAME_T) begin
                if (rx_nb == 14) dec_q.push_back(rx_sh);
                rx_active = 1'b0;
                rx_nb     = 0;
            end
        end
    end

    task automatic send(input logic [13:0] d);
        int n = 0;
        valid = 1'b1;
        data  = d;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_ready && n < 3 * T);
        check("send_ready_timeout", frame_ready, 1);
        @(posedge clk);
        #1 valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < 3 * T) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle_timeout", exp_q.size() == 0, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [13:0] d;

        @(posedge clk);
        #2;
        check("reset_key_tx", key_tx, 1);
        check("reset_busy", tx_busy, 0);
        check("reset_done", frame_done, 0);
        check("reset_err", frame_err, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        send(14'h1FFD);
        wait_idle();
        send(14'h1FFE);
        wait_idle();

        send(14'h2001);
        wait_idle();

        // New data held valid through a frame: only accepted on the IDLE cycle after FRAME_DONE.
        valid = 1'b1;
        data  = 14'h0A5C;
        n = 0;
        do begin @(negedge clk); n++; end while (!frame_ready && n < 3 * T);
        @(posedge clk);
        #1 data = 14'h1357;
        n = 0;
        do begin @(negedge clk); n++; end while (!frame_ready && n < 3 * T);
        check("accept_on_done_cycle", frame_done, 1);
        @(posedge clk);
        #1 valid = 1'b0;
        wait_idle();

        for (int i = 0; i < 6; i++) begin
            d = 14'($urandom_range(0, 'h1FFF));
            if ($urandom_range(0, 3) == 0) d[13] = 1'b1;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1 send(d);
            wait_idle();
        end

        // Reset during HOLD of cell 7, checked before any further clock edge.
        send(14'h0F0F);
        repeat (7 * (PRE + HOLD) + PRE + 5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_key_tx", key_tx, 1);
        check("abort_busy", tx_busy, 0);
        check("abort_ready", frame_ready, 1);
        check("abort_done", frame_done, 0);
        exp_q.delete();
        exp_data_q.delete();
        dec_q.delete();
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        send(14'h0C3A);
        wait_idle();

`ifdef KEY_FRAME_TX_REPEAT_EN
        begin
            int start;
            start = done_seen;
            rep = 1'b1;
            send(14'h05A9);
            n = 0;
            while (done_seen - start < 2 && n < 4 * T) begin
                @(negedge clk);
                n++;
            end
            check("repeat_second_done", done_seen - start, 2);
            @(posedge clk);
            #1 rep = 1'b0;
            wait_idle();
            check("repeat_done_count", done_seen - start, 3);
        end
`endif

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
